// File: rtl/ysyx_22050598_regfile_sb.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register busy scoreboard for decode hazard detection. x0 reads as zero
// and is never busy. rst is asynchronous and active-low.
module ysyx_22050598_regfile_sb #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int NR_RD  = 2,
  parameter int NR_WR  = 2,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NR_RD*AW-1:0]   rd_idx,
  output logic [NR_RD*XLEN-1:0] rd_data,
  output logic [NR_RD-1:0]      rd_busy,
  input  logic [NR_WR-1:0]      wr_en,
  input  logic [NR_WR*AW-1:0]   wr_idx,
  input  logic [NR_WR*XLEN-1:0] wr_data,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  input  logic                  flush,
  output logic [63:0]           ebreak_a0
);

  // x0 is not stored; entries 1..NREG-1 only.
  logic [XLEN-1:0] regs_q [1:NREG-1];
  logic [XLEN-1:0] regs_d [1:NREG-1];
  logic [NREG-1:1] busy_q;
  logic [NREG-1:1] busy_d;

  // A read/bypass index is meaningful only if it names a real, non-zero register.
  function automatic logic idx_ok(input logic [AW-1:0] i);
    return (i != '0) && (32'(i) < 32'(NREG));
  endfunction

  // Merge write ports into next register state; later ports override earlier ones.
  always_comb begin
    for (int r = 1; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
      for (int w = 0; w < NR_WR; w++) begin
        if (wr_en[w] && (wr_idx[w*AW +: AW] == AW'(r))) begin
          regs_d[r] = wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Scoreboard next state: flush beats issue, issue beats writeback clear.
  always_comb begin
    logic wb_hit;
    wb_hit = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      wb_hit = 1'b0;
      for (int w = 0; w < NR_WR; w++) begin
        if (wr_en[w] && (wr_idx[w*AW +: AW] == AW'(r))) begin
          wb_hit = 1'b1;
        end
      end
      busy_d[r] = busy_q[r];
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (iss_valid && (iss_rd == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wb_hit) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  // State registers; reset clears data and busy bits and drops in-flight writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 1; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
    end
  end

  // Combinational read: stored value, then optional forwarding of the winning
  // same-cycle write, which also masks busy since the data is now available.
  // Forwarding is suppressed during reset so outputs show the cleared contents.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NR_RD; p++) begin
      for (int r = 1; r < NREG; r++) begin
        if (rd_idx[p*AW +: AW] == AW'(r)) begin
          rd_data[p*XLEN +: XLEN] = regs_q[r];
          rd_busy[p]              = busy_q[r];
        end
      end
      if ((BYPASS != 0) && rst && idx_ok(rd_idx[p*AW +: AW])) begin
        for (int w = 0; w < NR_WR; w++) begin
          if (wr_en[w] && (wr_idx[w*AW +: AW] == rd_idx[p*AW +: AW])) begin
            rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
            rd_busy[p]              = 1'b0;
          end
        end
      end
    end
  end

  // a0 (x10) for the ebreak/trap handler: stored value only, no forwarding.
  generate
    if (NREG > 10) begin : g_a0
      assign ebreak_a0 = 64'(regs_q[10]);
    end else begin : g_no_a0
      assign ebreak_a0 = '0;
    end
  endgenerate

endmodule
